inv_square_recip: RTL and testbench

//  Reverse of the InvertSQRoot datapath: takes y (IEEE-754 single) and returns x = 1/(y*y).

---
 rtl/inv_square_recip.sv | 194 +++++++++++++++++++
 tb/tb_inv_square_recip.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/inv_square_recip.sv
// inv_square_recip: x = 1/(y*y) for an IEEE-754 single y, using one shared 32x32 multiplier
// and a multicycle FSM (square, seed, ITER Newton-Raphson reciprocal passes, pack).
module inv_square_recip #(
    parameter int unsigned ITER   = 3,
    parameter logic [31:0] SEED_A = 32'hB4B4B4B4,
    parameter logic [31:0] SEED_B = 32'h78787878
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] DataIn,
    input  logic        DataInValid,
    output logic        InReady,
    output logic [31:0] DataOut,
    output logic        DataOutValid,
    input  logic        DataOutReady
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SQUARE = 3'd1,
        S_SEED   = 3'd2,
        S_MUL_T  = 3'd3,
        S_MUL_R  = 3'd4,
        S_PACK   = 3'd5,
        S_DONE   = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        C_NORMAL = 2'd0,
        C_ZERO   = 2'd1,
        C_INF    = 2'd2,
        C_NAN    = 2'd3
    } class_e;

    localparam logic [31:0] TWO_Q30  = 32'h8000_0000;
    localparam logic [31:0] POS_INF  = 32'h7F80_0000;
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;
    localparam logic [2:0]  LAST_IT  = 3'(ITER - 1);

    state_e             state_q;
    class_e             cls_q;
    logic [7:0]         exp_q;
    logic [22:0]        frac_q;
    logic [31:0]        ms_q;
    logic [31:0]        r_q;
    logic [31:0]        e_q;
    logic signed [9:0]  es_q;
    logic [2:0]         iter_q;
    logic [31:0]        dout_q;
    logic               dv_q;

    logic [31:0]        mul_a;
    logic [31:0]        mul_b;
    logic [63:0]        prod;
    class_e             cls_d;
    logic [31:0]        ms_d;
    logic signed [9:0]  es_d;
    logic [31:0]        seed_d;
    logic               k_d;
    logic signed [9:0]  eo_d;
    logic [22:0]        mant_d;
    logic [31:0]        result_d;
    logic               unused_bits;

    assign InReady      = (state_q == S_IDLE);
    assign DataOut      = dout_q;
    assign DataOutValid = dv_q;

    // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        mul_a = 32'd0;
        mul_b = 32'd0;
        case (state_q)
            S_SQUARE: begin
                mul_a = {8'd0, 1'b1, frac_q};
                mul_b = {8'd0, 1'b1, frac_q};
            end
            S_SEED: begin
                mul_a = SEED_B;
                mul_b = ms_q;
            end
            S_MUL_T: begin
                mul_a = ms_q;
                mul_b = r_q;
            end
            S_MUL_R: begin
                mul_a = r_q;
                mul_b = e_q;
            end
            default: ;
        endcase
    end

    assign prod = 64'(mul_a) * 64'(mul_b);

    always_comb begin
        cls_d = C_NORMAL;
        if (DataIn[30:23] == 8'd0) begin
            cls_d = C_ZERO;
        end else if (DataIn[30:23] == 8'hFF) begin
            cls_d = (DataIn[22:0] == 23'd0) ? C_INF : C_NAN;
        end
    end

    // M*M is Q2.46 in [1,4); fold [2,4) down by one and keep the top Q2.30 bits.
    assign ms_d = prod[47] ? {1'b0, prod[47:17]} : prod[47:16];
    assign es_d = {1'b0, exp_q, 1'b0} - 10'd254 + {9'd0, prod[47]};

    // Linear seed evaluated on ms/2 in [0.5,1) and halved, so r0 approximates 1/ms in (0.5,1].
    assign seed_d = (SEED_A - {1'b0, prod[61:31]}) >> 1;

    always_comb begin
        k_d      = (frac_q != 23'd0);
        mant_d   = k_d ? r_q[28:6] : 23'd0;
        eo_d     = 10'sd127 - es_q - (k_d ? 10'sd1 : 10'sd0);
        result_d = 32'd0;
        case (cls_q)
            C_ZERO:  result_d = POS_INF;
            C_INF:   result_d = 32'd0;
            C_NAN:   result_d = QNAN;
            default: begin
                if (eo_d <= 10'sd0) begin
                    result_d = 32'd0;
                end else if (eo_d >= 10'sd255) begin
                    result_d = POS_INF;
                end else begin
                    result_d = {1'b0, eo_d[7:0], mant_d};
                end
            end
        endcase
    end

    // NOTE: state and datapath registers use non-blocking assignments so every read sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cls_q   <= C_NORMAL;
            exp_q   <= 8'd0;
            frac_q  <= 23'd0;
            ms_q    <= 32'd0;
            r_q     <= 32'd0;
            e_q     <= 32'd0;
            es_q    <= 10'sd0;
            iter_q  <= 3'd0;
            dout_q  <= 32'd0;
            dv_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (DataInValid) begin
                        exp_q   <= DataIn[30:23];
                        frac_q  <= DataIn[22:0];
                        cls_q   <= cls_d;
                        iter_q  <= 3'd0;
                        state_q <= S_SQUARE;
                    end
                end
                S_SQUARE: begin
                    ms_q    <= ms_d;
                    es_q    <= es_d;
                    state_q <= S_SEED;
                end
                S_SEED: begin
                    r_q     <= seed_d;
                    state_q <= S_MUL_T;
                end
                S_MUL_T: begin
                    e_q     <= TWO_Q30 - prod[61:30];
                    state_q <= S_MUL_R;
                end
                S_MUL_R: begin
                    r_q     <= prod[61:30];
                    iter_q  <= iter_q + 3'd1;
                    state_q <= (iter_q == LAST_IT) ? S_PACK : S_MUL_T;
                end
                S_PACK: begin
                    dout_q  <= result_d;
                    dv_q    <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    if (DataOutReady) begin
                        dv_q    <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign unused_bits = ^{DataIn[31], prod[63:62], prod[15:0]};

endmodule

// File: tb/tb_inv_square_recip.sv
// Directed bench for inv_square_recip: exact powers of two, a +-2 ulp sweep against a real model,
// specials, output back-pressure and mid-operation reset.
module tb_inv_square_recip;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] DataIn;
    logic        DataInValid;
    logic        InReady;
    logic [31:0] DataOut;
    logic        DataOutValid;
    logic        DataOutReady;

    int checks   = 0;
    int failures = 0;

    inv_square_recip dut (
        .clk          (clk),
        .rst          (rst),
        .DataIn       (DataIn),
        .DataInValid  (DataInValid),
        .InReady      (InReady),
        .DataOut      (DataOut),
        .DataOutValid (DataOutValid),
        .DataOutReady (DataOutReady)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        int diff;
        diff = int'(obs) - int'(exp);
        checks++;
        assert ((^obs !== 1'bx) && diff >= -2 && diff <= 2) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h (+-2 ulp)", tag, obs, exp);
        end
    endtask

    // Correctly rounded 1/y^2 for normal y whose result is a normal single.
    function automatic logic [31:0] ref_inv_sq(input logic [31:0] y);
        real    m;
        real    x;
        int     ex;
        longint mi;
        m  = 1.0 + real'(y[22:0]) / 8388608.0;
        x  = 1.0 / (m * m);
        ex = -2 * (int'(y[30:23]) - 127);
        while (x >= 2.0) begin x = x / 2.0; ex++; end
        while (x < 1.0)  begin x = x * 2.0; ex--; end
        mi = longint'(x * 8388608.0);
        if (mi == 64'sd16777216) begin
            mi = 64'sd8388608;
            ex++;
        end
        return {1'b0, 8'(ex + 127), mi[22:0]};
    endfunction

    task automatic accept(input logic [31:0] y);
        int guard = 0;
        while (InReady !== 1'b1 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check("in_ready_before_accept", {31'd0, InReady}, 32'd1);
        DataIn      = y;
        DataInValid = 1'b1;
        @(posedge clk); #1;
        DataInValid = 1'b0;
    endtask

    // Cycle index of the first DataOutValid=1 cycle, counting the accept cycle as 0.
    task automatic wait_out(output int lat);
        lat = 1;
        while (DataOutValid !== 1'b1 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        check("out_valid_seen", {31'd0, DataOutValid}, 32'd1);
    endtask

    task automatic run(input logic [31:0] y, output logic [31:0] res, output int lat);
        accept(y);
        wait_out(lat);
        res          = DataOut;
        DataOutReady = 1'b1;
        @(posedge clk); #1;
        DataOutReady = 1'b0;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] res;
        logic [31:0] y;
        logic [31:0] held;
        int          lat;
        logic [31:0] spec_in  [5];
        logic [31:0] spec_out [5];

        rst          = 1'b0;
        DataIn       = 32'd0;
        DataInValid  = 1'b0;
        DataOutReady = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready",  {31'd0, InReady},      32'd1);
        check("reset_out_valid", {31'd0, DataOutValid}, 32'd0);
        check("reset_data_out",  DataOut,               32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        run(32'h3F80_0000, res, lat);
        check("one_result",  res, 32'h3F80_0000);
        check("one_latency", 32'(lat), 32'd10);
        check("done_valid_dropped", {31'd0, DataOutValid}, 32'd0);
        check("done_in_ready_back", {31'd0, InReady},      32'd1);

        run(32'h4000_0000, res, lat);
        check("two_result", res, 32'h3E80_0000);
        run(32'hBF00_0000, res, lat);
        check("neg_half_result", res, 32'h4080_0000);
        run(32'h4040_0000, res, lat);
        check_near("three_result", res, 32'h3DE3_8E39);

        for (int i = 0; i < 1000; i++) begin
            y = {1'($urandom), 8'($urandom_range(187, 67)), 23'($urandom)};
            run(y, res, lat);
            check_near("sweep_result", res, ref_inv_sq(y));
        end

        spec_in[0] = 32'h0000_0000; spec_out[0] = 32'h7F80_0000;
        spec_in[1] = 32'h7F80_0000; spec_out[1] = 32'h0000_0000;
        spec_in[2] = 32'h7FC0_0001; spec_out[2] = 32'h7FC0_0000;
        spec_in[3] = 32'h1C80_0000; spec_out[3] = 32'h7F80_0000;
        spec_in[4] = 32'h6280_0000; spec_out[4] = 32'h0000_0000;
        for (int i = 0; i < 5; i++) begin
            run(spec_in[i], res, lat);
            check("special_result",  res,      spec_out[i]);
            check("special_latency", 32'(lat), 32'd10);
        end

        accept(32'h4000_0000);
        wait_out(lat);
        held = DataOut;
        check("hold_first_value", held, 32'h3E80_0000);
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                DataIn      = 32'h4040_0000;
                DataInValid = 1'b1;
            end
            @(posedge clk); #1;
            DataInValid = 1'b0;
            check("hold_valid",    {31'd0, DataOutValid}, 32'd1);
            check("hold_data",     DataOut,               held);
            check("hold_in_ready", {31'd0, InReady},      32'd0);
        end
        DataOutReady = 1'b1;
        @(posedge clk); #1;
        DataOutReady = 1'b0;
        check("release_valid_dropped", {31'd0, DataOutValid}, 32'd0);
        run(32'h3F80_0000, res, lat);
        check("after_hold_result",  res,      32'h3F80_0000);
        check("after_hold_latency", 32'(lat), 32'd10);

        // Cycles after accept: SQUARE, SEED, MUL_T, MUL_R, then second MUL_T.
        accept(32'h4000_0000);
        repeat (4) @(posedge clk);
        #1;
        check("busy_in_ready", {31'd0, InReady}, 32'd0);
        rst = 1'b0;
        #1;
        check("abort_valid",    {31'd0, DataOutValid}, 32'd0);
        check("abort_data",     DataOut,               32'd0);
        check("abort_in_ready", {31'd0, InReady},      32'd1);
        repeat (2) @(posedge clk);
        #1;
        check("abort_no_output", {31'd0, DataOutValid}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        run(32'h4000_0000, res, lat);
        check("post_reset_result",  res,      32'h3E80_0000);
        check("post_reset_latency", 32'(lat), 32'd10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
